// File: rtl/enable_reg_arb_if.sv
// Requester/bank bundle for the enable-register write arbiter.
// The arbiter takes the slave view; requesters and the bank see the master view.
interface enable_reg_arb_if #(
    parameter int NREQ  = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
);
    logic                 stall;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREGS-1:0]     reg_en;
    logic [DW-1:0]        reg_din;
    logic                 addr_err;
    logic [15:0]          wr_count;

    modport master (
        output stall, req, req_addr, req_data,
        input  gnt, reg_en, reg_din, addr_err, wr_count
    );

    modport slave (
        input  stall, req, req_addr, req_data,
        output gnt, reg_en, reg_din, addr_err, wr_count
    );
endinterface

// File: rtl/enable_reg_arb.sv
// Round-robin write arbiter driving the enable strobes and data bus
// of a register bank; one write per cycle, registered one cycle after grant.
module enable_reg_arb #(
    parameter int NREQ  = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    enable_reg_arb_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    r_ptr;
    logic [NREGS-1:0] r_reg_en;
    logic [DW-1:0]    r_reg_din;
    logic             r_addr_err;
    logic [15:0]      r_wr_count;

    logic             w_any;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_ptr_nxt;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_data;
    logic             w_valid;
    int               w_idx;

    // Search ascending from the pointer, wrapping; first requester wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_any && bus.req[w_idx]) begin
                w_any = 1'b1;
                w_win = PW'(w_idx);
            end
        end
        if (rst || bus.stall) begin
            w_any = 1'b0;
        end
    end

    always_comb begin
        w_addr    = bus.req_addr[int'(w_win)*AW +: AW];
        w_data    = bus.req_data[int'(w_win)*DW +: DW];
        w_valid   = (32'(w_addr) < NREGS);
        w_ptr_nxt = (w_win == PW'(NREQ-1)) ? '0 : w_win + PW'(1);
    end

    assign bus.gnt      = w_any ? (NREQ'(1) << w_win) : '0;
    assign bus.reg_en   = r_reg_en;
    assign bus.reg_din  = r_reg_din;
    assign bus.addr_err = r_addr_err;
    assign bus.wr_count = r_wr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_reg_en   <= '0;
            r_reg_din  <= '0;
            r_addr_err <= 1'b0;
            r_wr_count <= '0;
        end else if (w_any) begin
            r_ptr     <= w_ptr_nxt;
            r_reg_din <= w_data;
            if (w_valid) begin
                r_reg_en   <= NREGS'(1) << w_addr;
                r_addr_err <= 1'b0;
                r_wr_count <= r_wr_count + 16'd1;
            end else begin
                r_reg_en   <= '0;
                r_addr_err <= 1'b1;
            end
        end else begin
            r_reg_en   <= '0;
            r_addr_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_enable_reg_arb.sv
// Directed bench for enable_reg_arb: an 8-register instance and a
// 6-register instance for out-of-range addresses.
module tb_enable_reg_arb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_cnt;

    enable_reg_arb_if #(.NREQ(4), .NREGS(8), .AW(3), .DW(32)) bus ();
    enable_reg_arb_if #(.NREQ(4), .NREGS(6), .AW(3), .DW(32)) bus6 ();

    enable_reg_arb #(.NREQ(4), .NREGS(8), .AW(3), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    enable_reg_arb #(.NREQ(4), .NREGS(6), .AW(3), .DW(32)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt got %b want 0000", bus.gnt);
            end
            checks++;
            if (bus6.gnt !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt6 got %b want 0000", bus6.gnt);
            end
        end
        checks++;
        if (bus.reg_en !== 8'h00) begin
            errors++;
            $display("FAIL reset_en got %h want 00", bus.reg_en);
        end
        checks++;
        if (bus.reg_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_din got %h want 0", bus.reg_din);
        end
        checks++;
        if (bus.wr_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", bus.wr_count);
        end
        checks++;
        if (bus.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", bus.addr_err);
        end
        step();
        rst      = 1'b0;
        bus.req  = '0;
        bus6.req = '0;
    endtask

    task automatic test_single();
        bus.req              = 4'b0100;
        bus.req_addr[6 +: 3] = 3'd3;
        bus.req_data[64 +: 32] = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL single_gnt got %b want 0100", bus.gnt);
        end
        step();
        bus.req = '0;
        exp_cnt = 1;
        checks++;
        if (bus.reg_en !== 8'h08) begin
            errors++;
            $display("FAIL single_en got %h want 08", bus.reg_en);
        end
        checks++;
        if (bus.reg_din !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_din got %h want deadbeef", bus.reg_din);
        end
        checks++;
        if (bus.wr_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL single_cnt got %0d want %0d", bus.wr_count, exp_cnt);
        end
        step();
        checks++;
        if (bus.reg_en !== 8'h00) begin
            errors++;
            $display("FAIL single_en_clr got %h want 00", bus.reg_en);
        end
        checks++;
        if (bus.reg_din !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_din_hold got %h want deadbeef", bus.reg_din);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0] ens [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                8'h01, 8'h02, 8'h04, 8'h08};
        // ptr is 3 after the single write; one grant to req3 brings it to 0
        bus.req = 4'b1000;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL rr_prep_gnt got %b want 1000", bus.gnt);
        end
        step();
        exp_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*3 +: 3]   = 3'(i);
            bus.req_data[i*32 +: 32] = 32'h100 + 32'(i);
        end
        bus.req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== seq[c]) begin
                errors++;
                $display("FAIL rr_gnt[%0d] got %b want %b", c, bus.gnt, seq[c]);
            end
            step();
            exp_cnt++;
            checks++;
            if (bus.reg_en !== ens[c]) begin
                errors++;
                $display("FAIL rr_en[%0d] got %h want %h", c, bus.reg_en, ens[c]);
            end
        end
        bus.req = '0;
        checks++;
        if (bus.wr_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL rr_cnt got %0d want %0d", bus.wr_count, exp_cnt);
        end
    endtask

    task automatic test_skip_wrap();
        bus.req = 4'b0100;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_prep_gnt got %b want 0100", bus.gnt);
        end
        step();
        bus.req = 4'b0101;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_gnt0 got %b want 0001", bus.gnt);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_gnt2 got %b want 0100", bus.gnt);
        end
        step();
        bus.req = '0;
        exp_cnt += 3;
    endtask

    task automatic test_stall();
        step();
        bus.stall              = 1'b1;
        bus.req                = 4'b0010;
        bus.req_addr[3 +: 3]   = 3'd5;
        bus.req_data[32 +: 32] = 32'h0BADF00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0000) begin
                errors++;
                $display("FAIL stall_gnt[%0d] got %b want 0000", c, bus.gnt);
            end
            checks++;
            if (bus.reg_en !== 8'h00) begin
                errors++;
                $display("FAIL stall_en[%0d] got %h want 00", c, bus.reg_en);
            end
            step();
        end
        bus.stall = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL stall_rel_gnt got %b want 0010", bus.gnt);
        end
        step();
        // stall right after the grant must not cancel the registered write
        bus.stall = 1'b1;
        exp_cnt++;
        checks++;
        if (bus.reg_en !== 8'h20) begin
            errors++;
            $display("FAIL stall_en_done got %h want 20", bus.reg_en);
        end
        checks++;
        if (bus.wr_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL stall_cnt got %0d want %0d", bus.wr_count, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL stall_regnt got %b want 0000", bus.gnt);
        end
        step();
        checks++;
        if (bus.reg_en !== 8'h00) begin
            errors++;
            $display("FAIL stall_en_clr got %h want 00", bus.reg_en);
        end
        bus.stall = 1'b0;
        bus.req   = '0;
    endtask

    task automatic test_bad_addr();
        bus6.req                = 4'b0001;
        bus6.req_addr[0 +: 3]   = 3'd7;
        bus6.req_data[0 +: 32]  = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (bus6.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL bad_gnt got %b want 0001", bus6.gnt);
        end
        step();
        bus6.req_addr[0 +: 3]  = 3'd6;
        bus6.req_data[0 +: 32] = 32'h12345678;
        checks++;
        if (bus6.reg_en !== 6'h00) begin
            errors++;
            $display("FAIL bad7_en got %h want 00", bus6.reg_en);
        end
        checks++;
        if (bus6.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL bad7_err got %b want 1", bus6.addr_err);
        end
        checks++;
        if (bus6.wr_count !== 16'd0) begin
            errors++;
            $display("FAIL bad7_cnt got %0d want 0", bus6.wr_count);
        end
        checks++;
        if (bus6.reg_din !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL bad7_din got %h want cafef00d", bus6.reg_din);
        end
        step();
        bus6.req_addr[0 +: 3]  = 3'd5;
        bus6.req_data[0 +: 32] = 32'h0000A5A5;
        checks++;
        if (bus6.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL bad6_err got %b want 1", bus6.addr_err);
        end
        checks++;
        if (bus6.reg_din !== 32'h12345678) begin
            errors++;
            $display("FAIL bad6_din got %h want 12345678", bus6.reg_din);
        end
        step();
        bus6.req = '0;
        checks++;
        if (bus6.reg_en !== 6'h20) begin
            errors++;
            $display("FAIL ok5_en got %h want 20", bus6.reg_en);
        end
        checks++;
        if (bus6.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL ok5_err got %b want 0", bus6.addr_err);
        end
        checks++;
        if (bus6.wr_count !== 16'd1) begin
            errors++;
            $display("FAIL ok5_cnt got %0d want 1", bus6.wr_count);
        end
        step();
        checks++;
        if (bus6.reg_en !== 6'h00 || bus6.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL idle6 got en=%h err=%b want en=00 err=0",
                     bus6.reg_en, bus6.addr_err);
        end
    endtask

    task automatic test_reset_mid();
        bus.req                = 4'b0001;
        bus.req_addr[0 +: 3]   = 3'd4;
        bus.req_data[0 +: 32]  = 32'h77;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_gnt got %b want 0001", bus.gnt);
        end
        step();
        bus.req = 4'b1111;
        rst     = 1'b1;
        checks++;
        if (bus.reg_en !== 8'h10) begin
            errors++;
            $display("FAIL mid_pending got %h want 10", bus.reg_en);
        end
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_gnt got %b want 0000", bus.gnt);
        end
        step();
        rst = 1'b0;
        checks++;
        if (bus.reg_en !== 8'h00) begin
            errors++;
            $display("FAIL mid_en_clr got %h want 00", bus.reg_en);
        end
        checks++;
        if (bus.wr_count !== 16'd0 || bus.reg_din !== 32'h0) begin
            errors++;
            $display("FAIL mid_regs got cnt=%0d din=%h want cnt=0 din=0",
                     bus.wr_count, bus.reg_din);
        end
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr_gnt got %b want 0001", bus.gnt);
        end
        step();
        bus.req = '0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_cnt       = 0;
        rst           = 1'b1;
        bus.stall     = 1'b0;
        bus.req       = 4'b1111;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus6.stall    = 1'b0;
        bus6.req      = 4'b1111;
        bus6.req_addr = '0;
        bus6.req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_stall();
        test_bad_addr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/enable_reg_arb.md
Name: enable_reg_arb

Overview:
Round-robin write arbiter and sequencer for a bank of 32-bit enable registers.
NREQ requesters each present an address and a data word. The block grants one requester per cycle and drives the bank's per-register enable strobes and a shared data bus.
It sits between the requesting engines and the register bank. It is the only driver of the bank's en/din inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
NREGS, 8, number of registers in the bank (1..32)
AW, 3, address width; must be ≥ ceil(log2(NREGS)), min 1
DW, 32, data width

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  when high, no grant is issued this cycle
req  input  NREQ  per-requester write request, level
req_addr  input  NREQ*AW  packed; requester i uses bits [i*AW +: AW]
req_data  input  NREQ*DW  packed; requester i uses bits [i*DW +: DW]
gnt  output  NREQ  one-hot, combinational, same-cycle acceptance
reg_en  output  NREGS  registered one-hot write strobe to the bank
reg_din  output  DW  registered write data to the bank
addr_err  output  1  registered pulse; granted address was ≥ NREGS
wr_count  output  16  registered count of writes issued to the bank

Behaviour:
- Reset (synchronous, active-high; clk and rst as named above):
  - ptr=0, reg_en=0, reg_din=0, addr_err=0, wr_count=0.
  - gnt is 0 whenever rst is high.
- Arbitration (combinational):
  - Search req starting at index ptr, ascending, wrapping modulo NREQ.
  - The first set bit wins and gnt[winner]=1.
  - gnt=0 if req==0, stall=1 or rst=1.
  - At most one gnt bit is ever high.
- Handshake:
  - A request is accepted in the cycle gnt[i]=1.
  - The requester holds req/addr/data stable until it sees gnt.
  - After gnt the requester may keep req high with new addr/data to issue a back-to-back write. It then competes normally at the next edge.
- Pointer: on an edge where any gnt is high, ptr <= winner+1 mod NREQ. Otherwise ptr holds.
- Write path (one cycle after gnt):
  - Valid address (addr < NREGS): reg_en <= one-hot(addr), reg_din <= data, wr_count <= wr_count+1 (wraps 0xFFFF -> 0).
  - Invalid address (addr ≥ NREGS): reg_en <= 0, addr_err <= 1, reg_din <= data, wr_count unchanged.
  - No grant: reg_en <= 0, addr_err <= 0, reg_din holds its last value.
- Latency: gnt in cycle N -> reg_en/reg_din valid in cycle N+1 -> bank register updated at the N+1→N+2 edge.
- Throughput: one write per cycle, sustained.
- Fairness: with all NREQ requesters continuously requesting, each is granted exactly once every NREQ cycles.
- stall:
  - Blocks the grant and holds ptr.
  - A write already registered in reg_en still completes.
- Reset mid-operation:
  - A pending reg_en is cleared, so the bank sees no write.
  - Requests in flight and not yet granted are not remembered.
- Simultaneous grant and stall: not possible; stall wins.
- Two requesters targeting the same address in consecutive cycles: both writes are issued in grant order, and the later one wins in the bank.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, reg_en=0, reg_din=0, wr_count=0, addr_err=0.
2. Single write: after reset req=4'b0100, addr2=3, data2=0xDEADBEEF for 1 cycle -> gnt=4'b0100 that cycle; next cycle reg_en=8'h08, reg_din=0xDEADBEEF, wr_count=1; the cycle after, reg_en=0.
3. Round-robin: req=4'b1111 held for 8 cycles from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; wr_count=8.
4. Skip and wrap: ptr=3 (after granting req2), req=4'b0101 -> gnt=0001, ptr becomes 1; next cycle gnt=0100.
5. Stall: req=4'b0010, stall=1 for 3 cycles -> gnt=0 and reg_en=0 throughout; stall=0 -> gnt=0010 immediately, reg_en is one-hot(addr1) one cycle later.
6. Bad address: NREGS=6, AW=3, req0 with addr=7 -> gnt=0001; next cycle reg_en=0, addr_err=1 for 1 cycle, wr_count unchanged. Also assert rst during a cycle where reg_en is pending -> reg_en=0 on the next cycle.
